// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 asynchronous serial receiver with a one-entry valid/ready holding register
// Framing and overrun errors are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 625
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rxd_meta_q, rxd_meta_d;
  logic          rxd_s_q, rxd_s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_s_q     <= rxd_s_d;
    end
  end

  always_comb begin
    rxd_meta_d  = rxd;
    rxd_s_d     = rxd_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
            state_d = IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit
// Expected bytes and error counts come from a holding-register model driven per frame.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_ovr = 0;
  int         m_fe = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid) valid_cycles = valid_cycles + 1;
      if (rx_valid && !prev_valid) begin
        rise_cnt  = rise_cnt + 1;
        last_rise = cyc;
      end
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
      if (frame_err || overrun) begin
        vectors = vectors + 1;
        if (frame_err && overrun) begin
          miscompares = miscompares + 1;
          $display("FAIL exclusive: frame_err=%0b overrun=%0b at cycle %0d, required not both", frame_err, overrun, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = 1'b1;
    wait_cycles(CPB);
  endtask

  // Holding register outcome of one good frame: drain at stop, then load or overrun, then drain after.
  task automatic model_frame(input logic [7:0] b, input bit ready_at_stop, input bit ready_after);
    if (m_valid && ready_at_stop) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ovr = m_ovr + 1;
    end
    if (m_valid && ready_after) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_drain();
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic check_last(input string name, input logic [7:0] want);
    vectors = vectors + 1;
    if (got_q.size() == 0) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: no byte accepted, required %02h", name, want);
    end else if (got_q[got_q.size()-1] !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %02h, required %02h", name, got_q[got_q.size()-1], want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(4);
    vectors = vectors + 4;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b, required 0", rx_valid); end
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %02h, required 00", rx_data); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_fe: got %0b, required 0", frame_err); end
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ov: got %0b, required 0", overrun); end
    rst = 1'b0;
    wait_cycles(CPB);
  endtask

  task automatic test_basic();
    int r0, v0, f0, o0, start;
    r0 = rise_cnt; v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b1;
    start = cyc;
    send_frame(8'h41);
    model_frame(8'h41, 1'b1, 1'b1);
    wait_cycles(4);
    vectors = vectors + 5;
    if (rise_cnt - r0 !== 1) begin miscompares++; $display("FAIL basic_rise: got %0d, required 1", rise_cnt - r0); end
    if (valid_cycles - v0 !== 1) begin miscompares++; $display("FAIL basic_width: got %0d, required 1", valid_cycles - v0); end
    if ((last_rise - start) < LAT - 2 || (last_rise - start) > LAT + 2) begin
      miscompares++; $display("FAIL basic_latency: got %0d, required %0d +/-2", last_rise - start, LAT);
    end
    if (fe_cnt - f0 !== 0) begin miscompares++; $display("FAIL basic_fe: got %0d, required 0", fe_cnt - f0); end
    if (ov_cnt - o0 !== 0) begin miscompares++; $display("FAIL basic_ov: got %0d, required 0", ov_cnt - o0); end
    check_last("basic_data", 8'h41);
  endtask

  task automatic test_back_to_back();
    int o0, mo0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h0F;
    o0 = ov_cnt; mo0 = m_ovr;
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(bytes[i]);
      model_frame(bytes[i], 1'b0, 1'b0);
    end
    wait_cycles(2);
    vectors = vectors + 3;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %0b, required 1", rx_valid); end
    if (rx_data !== m_data) begin miscompares++; $display("FAIL b2b_data: got %02h, required %02h", rx_data, m_data); end
    if (ov_cnt - o0 !== m_ovr - mo0) begin miscompares++; $display("FAIL b2b_overrun: got %0d, required %0d", ov_cnt - o0, m_ovr - mo0); end
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    model_drain();
    vectors = vectors + 1;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %0b, required 0", rx_valid); end
    wait_cycles(CPB);
  endtask

  task automatic test_drain_and_load();
    int o0;
    rx_ready = 1'b0;
    send_frame(8'h12);
    model_frame(8'h12, 1'b0, 1'b0);
    wait_cycles(2);
    o0 = ov_cnt;
    fork
      send_frame(8'h34);
      begin
        wait_cycles(LAT - 1);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    model_frame(8'h34, 1'b1, 1'b0);
    wait_cycles(2);
    vectors = vectors + 3;
    if (ov_cnt - o0 !== 0) begin miscompares++; $display("FAIL dl_overrun: got %0d, required 0", ov_cnt - o0); end
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL dl_valid: got %0b, required 1", rx_valid); end
    if (rx_data !== m_data) begin miscompares++; $display("FAIL dl_data: got %02h, required %02h", rx_data, m_data); end
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    model_drain();
    wait_cycles(CPB);
  endtask

  task automatic test_start_glitch();
    int r0, f0, o0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rxd = 1'b0;
    wait_cycles(5);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    vectors = vectors + 3;
    if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL glitch_valid: got %0d, required 0", rise_cnt - r0); end
    if (fe_cnt - f0 !== 0) begin miscompares++; $display("FAIL glitch_fe: got %0d, required 0", fe_cnt - f0); end
    if (ov_cnt - o0 !== 0) begin miscompares++; $display("FAIL glitch_ov: got %0d, required 0", ov_cnt - o0); end
    rx_ready = 1'b1;
    send_frame(8'hC3);
    model_frame(8'hC3, 1'b1, 1'b1);
    wait_cycles(4);
    check_last("glitch_next", 8'hC3);
  endtask

  task automatic test_break();
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    rx_ready = 1'b1;
    rxd = 1'b0;
    wait_cycles(40 * CPB);
    rxd = 1'b1;
    m_fe = m_fe + 1;
    wait_cycles(CPB);
    vectors = vectors + 2;
    if (fe_cnt - f0 !== 1) begin miscompares++; $display("FAIL break_fe: got %0d, required 1", fe_cnt - f0); end
    if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL break_valid: got %0d, required 0", rise_cnt - r0); end
    send_frame(8'h7E);
    model_frame(8'h7E, 1'b1, 1'b1);
    wait_cycles(4);
    check_last("break_next", 8'h7E);
  endtask

  task automatic test_reset_midframe();
    int r0, f0;
    rx_ready = 1'b0;
    send_frame(8'h99);
    model_frame(8'h99, 1'b0, 1'b0);
    wait_cycles(2);
    fork
      send_frame(8'hFF);
      begin
        wait_cycles(CPB + 4 * CPB + 8);
        rst = 1'b1;
        wait_cycles(1);
        vectors = vectors + 4;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %0b, required 0", rx_valid); end
        if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %02h, required 00", rx_data); end
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_fe: got %0b, required 0", frame_err); end
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_ov: got %0b, required 0", overrun); end
        rst = 1'b0;
      end
    join
    m_valid = 1'b0;
    r0 = rise_cnt; f0 = fe_cnt;
    wait_cycles(CPB);
    vectors = vectors + 2;
    if (rise_cnt - r0 !== 0) begin miscompares++; $display("FAIL rstmid_partial: got %0d deliveries, required 0", rise_cnt - r0); end
    if (fe_cnt - f0 !== 0) begin miscompares++; $display("FAIL rstmid_fe_after: got %0d, required 0", fe_cnt - f0); end
    rx_ready = 1'b1;
    send_frame(8'hA5);
    model_frame(8'hA5, 1'b1, 1'b1);
    wait_cycles(4);
    check_last("rstmid_next", 8'hA5);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rx_ready = 1'b1;
        send_frame(b);
        model_frame(b, 1'b1, 1'b1);
      end else begin
        rx_ready = 1'b0;
        send_frame(b);
        model_frame(b, 1'b0, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          rx_ready = 1'b1;
          wait_cycles(1);
          rx_ready = 1'b0;
          model_drain();
        end
      end
      wait_cycles($urandom_range(0, 20));
    end
    rx_ready = 1'b1;
    wait_cycles(4);
    rx_ready = 1'b0;
    model_drain();
  endtask

  task automatic test_scoreboard();
    vectors = vectors + 3;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL sb_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    if (ov_cnt !== m_ovr) begin miscompares++; $display("FAIL sb_overrun: got %0d, required %0d", ov_cnt, m_ovr); end
    if (fe_cnt !== m_fe) begin miscompares++; $display("FAIL sb_frame_err: got %0d, required %0d", fe_cnt, m_fe); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors = vectors + 1;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL sb_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_drain_and_load();
    test_start_glitch();
    test_break();
    test_reset_midframe();
    test_random();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
